// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants and state type
//   rx_state_t     : framing FSM states
//   ETH_*          : preamble and start-of-frame delimiter bytes
//   CRC32_*        : reflected CRC-32 polynomial, seed and good-frame residue
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Register value after running data plus its own FCS through the CRC
  // with no final inversion.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/gmii_rx_mac_if.sv
// rtl/gmii_rx_mac_if.sv - byte-wide output stream bundle of the receive MAC
//   tdata  : payload byte
//   tvalid : beat valid, no tready (sink always accepts)
//   tlast  : last payload byte of a frame
//   tuser  : bad frame, meaningful only with tlast
//   master : driven by the MAC
//   slave  : consumed by the downstream parser
interface gmii_rx_mac_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);

endinterface

// File: rtl/crc32_byte.sv
// rtl/crc32_byte.sv - combinational one-byte step of the reflected CRC-32
//   crc_i  : current CRC register
//   data_i : byte to absorb, LSB first
//   crc_o  : CRC register after the byte (no final inversion)
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_mac.sv
// rtl/gmii_rx_mac.sv - GMII receive framing: preamble/SFD strip, FCS strip and check
//   gmii_rx_clk     : single 125 MHz receive clock
//   rst             : synchronous active-high reset
//   gmii_rx_dv/rxd/rx_er : GMII receive inputs
//   m_axis          : payload stream (tdata/tvalid/tlast/tuser), registered
//   stat_frames_ok  : wrapping count of good frames
//   stat_frames_bad : wrapping count of bad frames, beatless ones included
module gmii_rx_mac
  import eth_pkg::*;
#(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic          gmii_rx_clk,
  input  logic          rst,
  input  logic          gmii_rx_dv,
  input  logic [7:0]    gmii_rxd,
  input  logic          gmii_rx_er,
  gmii_rx_mac_if.master m_axis,
  output logic [31:0]   stat_frames_ok,
  output logic [31:0]   stat_frames_bad
);

  localparam int LEN_W = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);

  rx_state_t        state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  // Four-byte delay line: the newest four bytes are candidate FCS bytes, so
  // a byte is only known to be payload once four more bytes arrive.
  logic [7:0]       dly_q [4];
  logic [2:0]       fill_q;
  // The byte pushed out of the delay line waits here; it is emitted when the
  // next byte arrives (tlast=0) or at end of frame (tlast=1).
  logic [7:0]       pend_q;
  logic             pend_vld_q;

  logic [7:0]       tdata_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic             tuser_q;
  logic [31:0]      ok_q;
  logic [31:0]      bad_q;

  logic             frame_bad;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd),
    .crc_o  (crc_d)
  );

  always_comb begin
    frame_bad = (crc_q != CRC32_RESIDUE) || (len_q < LEN_MIN) || err_q;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= CRC32_INIT;
      len_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < 4; i++) dly_q[i] <= 8'h00;
      fill_q     <= 3'd0;
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      ok_q       <= 32'd0;
      bad_q      <= 32'd0;
    end else begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;

      case (state_q)
        IDLE, PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_q <= IDLE;
          end else if (gmii_rxd == ETH_PREAMBLE) begin
            state_q <= PREAMBLE;
          end else if (gmii_rxd == ETH_SFD) begin
            state_q    <= PAYLOAD;
            crc_q      <= CRC32_INIT;
            len_q      <= '0;
            err_q      <= 1'b0;
            fill_q     <= 3'd0;
            pend_vld_q <= 1'b0;
          end else begin
            state_q <= DROP;
          end
        end

        PAYLOAD: begin
          if (!gmii_rx_dv) begin
            if (pend_vld_q) begin
              tdata_q  <= pend_q;
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b1;
              tuser_q  <= frame_bad;
            end
            if (frame_bad) bad_q <= bad_q + 32'd1;
            else           ok_q  <= ok_q + 32'd1;
            pend_vld_q <= 1'b0;
            state_q    <= IDLE;
          end else if (len_q == LEN_MAX) begin
            // This byte would push the frame past MAX_FRAME: close the
            // stream now as bad and discard the remainder.
            if (pend_vld_q) begin
              tdata_q  <= pend_q;
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b1;
              tuser_q  <= 1'b1;
            end
            bad_q      <= bad_q + 32'd1;
            len_q      <= LEN_SAT;
            pend_vld_q <= 1'b0;
            state_q    <= DROP;
          end else begin
            crc_q <= crc_d;
            len_q <= len_q + LEN_W'(1);
            if (gmii_rx_er) err_q <= 1'b1;
            dly_q[0] <= gmii_rxd;
            dly_q[1] <= dly_q[0];
            dly_q[2] <= dly_q[1];
            dly_q[3] <= dly_q[2];
            if (fill_q == 3'd4) begin
              pend_q     <= dly_q[3];
              pend_vld_q <= 1'b1;
              if (pend_vld_q) begin
                tdata_q  <= pend_q;
                tvalid_q <= 1'b1;
              end
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
        end

        DROP: begin
          if (!gmii_rx_dv) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata     = tdata_q;
  assign m_axis.tvalid    = tvalid_q;
  assign m_axis.tlast     = tlast_q;
  assign m_axis.tuser     = tuser_q;
  assign stat_frames_ok   = ok_q;
  assign stat_frames_bad  = bad_q;

endmodule

// File: tb/tb_gmii_rx_mac.sv
// tb/tb_gmii_rx_mac.sv - scoreboard bench for gmii_rx_mac
module tb_gmii_rx_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_er = 1'b0;
  logic [31:0] stat_frames_ok;
  logic [31:0] stat_frames_bad;

  gmii_rx_mac_if m_axis_if ();

  gmii_rx_mac #(.MAX_FRAME(1518), .MIN_FRAME(64)) dut (
    .gmii_rx_clk     (clk),
    .rst             (rst),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_er      (gmii_rx_er),
    .m_axis          (m_axis_if),
    .stat_frames_ok  (stat_frames_ok),
    .stat_frames_bad (stat_frames_bad)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t       sb [$];
  logic [7:0]  pl [$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          beat_cnt = 0;
  int          mark = -1;
  int          mark_cyc = 0;
  int          first_byte_cyc = 0;
  logic [31:0] exp_ok = 0;
  logic [31:0] exp_bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (m_axis_if.tvalid === 1'b1) begin
      if (beat_cnt == mark) mark_cyc = cyc_cnt;
      beat_cnt = beat_cnt + 1;
      if (sb.size() == 0) begin
        check("spurious_tvalid", m_axis_if.tvalid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("tdata", m_axis_if.tdata, e.d);
        check("tlast", m_axis_if.tlast, e.l);
        if (e.l) check("tuser", m_axis_if.tuser, e.u);
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  // fcs_mode: 0 good FCS, 1 FCS byte 0 XOR 0x01, 2 no FCS appended.
  task automatic send_frame(input int npre, input int fcs_mode, input int er_idx);
    logic [7:0]  fr [$];
    logic [31:0] c;
    logic [31:0] fcs;
    int          n;
    int          nb;
    logic        fbad;
    logic        over;
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      fr.push_back(pl[i]);
      c = crc_upd(c, pl[i]);
    end
    fcs = ~c;
    if (fcs_mode == 1) fcs[0] = ~fcs[0];
    if (fcs_mode != 2) begin
      fr.push_back(fcs[7:0]);
      fr.push_back(fcs[15:8]);
      fr.push_back(fcs[23:16]);
      fr.push_back(fcs[31:24]);
    end
    n    = fr.size();
    over = (n > 1518);
    fbad = over || (fcs_mode != 0) || (er_idx >= 0) || (n < 64);
    nb   = over ? 1514 : n - 4;
    for (int k = 0; k < nb; k++) sb.push_back({fr[k], (k == nb - 1), fbad});
    if (fbad) exp_bad = exp_bad + 1;
    else      exp_ok  = exp_ok + 1;
    mark = beat_cnt + sb.size() - nb;
    for (int p = 0; p < npre; p++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, fr[k], (k == er_idx));
      if (k == 0) first_byte_cyc = cyc_cnt;
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    check({tag, "_beats_left"}, sb.size(), 0);
    check({tag, "_ok"}, stat_frames_ok, exp_ok);
    check({tag, "_bad"}, stat_frames_bad, exp_bad);
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_if.tvalid, 1'b0);
    check("rst_tlast", m_axis_if.tlast, 1'b0);
    check("rst_tuser", m_axis_if.tuser, 1'b0);
    check("rst_tdata", m_axis_if.tdata, 8'h00);
    check("rst_ok", stat_frames_ok, 32'd0);
    check("rst_bad", stat_frames_bad, 32'd0);
    rst = 1'b0;
    repeat (2) cyc(1'b0, 8'h00, 1'b0);

    fill_seq(60);
    send_frame(7, 0, -1);
    check("good_latency", mark_cyc - first_byte_cyc, 5);
    settle_and_check("good");

    send_frame(7, 1, -1);
    settle_and_check("badfcs");

    send_frame(7, 0, 10);
    settle_and_check("rxer");

    fill_seq(20);
    send_frame(7, 0, -1);
    settle_and_check("runt");

    fill_seq(3);
    send_frame(7, 2, -1);
    settle_and_check("tiny");

    fill_rand(1514);
    send_frame(7, 0, -1);
    settle_and_check("max_len");

    fill_rand(1515);
    send_frame(7, 0, -1);
    settle_and_check("max_plus1");

    fill_rand(1596);
    send_frame(7, 0, -1);
    settle_and_check("oversize");

    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h54, 1'b0);
    for (int p = 0; p < 4; p++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 8'(k + 1), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    fill_seq(60);
    send_frame(7, 0, -1);
    fill_rand(70);
    send_frame(0, 0, -1);
    settle_and_check("bad_preamble_then_good");

    fill_seq(60);
    for (int p = 0; p < 7; p++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < 25; k++) sb.push_back({8'(k), 1'b0, 1'b0});
    for (int k = 0; k < 30; k++) cyc(1'b1, pl[k], 1'b0);
    rst = 1'b1;
    cyc(1'b1, pl[30], 1'b0);
    rst = 1'b0;
    exp_ok  = 0;
    exp_bad = 0;
    for (int k = 31; k < 60; k++) cyc(1'b1, pl[k], 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'hA0 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    settle_and_check("midframe_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
